kbd_ps2_pia: RTL and testbench
==============================

KBD_PS2_PIA -- requirements
Module: kbd_ps2_pia

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, giving the number of consecutive stable clk cycles before a synchronized ps2_clk level is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20000, giving the number of clk cycles without a filtered ps2_clk falling edge that aborts a frame in progress.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1, asynchronous PS/2 keyboard clock.
REQ-006 SHALL have port ps2_data, input, 1, asynchronous PS/2 keyboard data.
REQ-007 SHALL have port kbd_data, output, 8, keyboard register: bit7 = key available, bits6:0 = ASCII.
REQ-008 SHALL have port kbd_clear, input, 1, one-cycle CPU strobe that acknowledges the current key.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse on a rejected or aborted frame.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse when a decoded key is dropped.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers, then filter ps2_clk per FILTER_LEN; the data bit is sampled on each filtered falling edge.
REQ-012 SHALL run a frame FSM: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
REQ-013 SHALL ignore a start bit of 1 and remain in IDLE, with no frame_err.
REQ-014 SHALL require odd parity over the 8 data bits plus the parity bit, and stop=1; on failure it SHALL pulse frame_err, discard the byte and return to IDLE.
REQ-015 SHALL, when TIMEOUT_CYC cycles pass without an edge in any state other than IDLE, return to IDLE and pulse frame_err.
REQ-016 SHALL treat scancode 0xF0 as setting a break flag and 0xE0 as setting an extended flag; both flags SHALL clear after the next non-prefix byte.
REQ-017 SHALL ignore every byte that has the extended flag set.
REQ-018 SHALL set shift_state on make of 0x12 or 0x59 and clear it on break of 0x12 or 0x59; shift keys produce no output.
REQ-019 SHALL produce no output for the break of any key other than a shift key.
REQ-020 SHALL translate non-extended make codes via the set-2 table:
- letters always uppercase;
- digits and punctuation shifted per US layout when shift_state=1;
- 0x5A -> 0x0D;
- 0x66 -> 0x5F;
- 0x29 -> 0x20;
- 0x76 -> 0x1B;
- unmapped codes ignored.
REQ-021 SHALL load a decoded character into kbd_data with bit7=1 exactly 2 clk cycles after the filtered edge that samples the stop bit.
REQ-022 SHALL, on kbd_clear, clear bit7 on the next cycle and retain bits6:0.
REQ-023 SHALL, when a new character and kbd_clear occur in the same cycle, load the new character with bit7=1.
REQ-024 SHALL, when a character arrives while bit7=1 (and no FIFO slot is free), drop the new character, keep the latch unchanged and pulse overrun.
REQ-025 SHALL never set bit7 as a result of a prefix byte, a break code or an error.

Reset
REQ-026 SHALL, on reset assertion, immediately:
- set kbd_data=0x00, frame_err=0 and overrun=0;
- put the FSM in IDLE;
- clear shift_state, the break flag and the extended flag;
- clear the filter and the timeout counter;
- empty the FIFO.
REQ-027 SHALL discard a frame that is partially received when reset asserts; the first frame accepted after reset release SHALL begin with a fresh start bit.

Configuration
REQ-028 SHALL, with KBD_FIFO_EN defined, insert a 4-entry type-ahead FIFO ahead of the latch:
- the latch refills from the FIFO on the cycle after kbd_clear;
- a character that arrives when the FIFO is full is dropped and overrun pulses;
- order is preserved.
REQ-029 SHALL, without KBD_FIFO_EN, use the single latch only, per REQ-024.

Structure
REQ-030 SHALL place the frame FSM state encoding, the scancode constants (0xF0, 0xE0, 0x12, 0x59, 0x5A, 0x66) and the ASCII constants in shared package mango_kbd_pkg.
REQ-031 SHALL implement the synchronizer, filter, frame FSM and timeout as sub-module ps2_rx, with outputs byte[7:0], byte_valid (1-cycle) and err (1-cycle).
REQ-032 SHALL keep the scancode translation table, the prefix and shift tracking, the latch and the optional FIFO in kbd_ps2_pia.

Verification
REQ-033 Frame 0x1C (parity bit 0, stop 1) -> kbd_data=0xC1 two cycles after the stop-bit edge.
REQ-034 Frames 0x12, 0x16, then F0 16, F0 12 -> exactly one key, 0xA1; after kbd_clear, kbd_data=0x21.
REQ-035 Frame 0x1C with parity bit 1 -> one frame_err pulse; kbd_data stays 0x00.
REQ-036 Start bit plus 4 data bits, then 20000 idle cycles -> frame_err pulse; a following valid 0x5A -> kbd_data=0x8D.
REQ-037 Without KBD_FIFO_EN: 0x1C then 0x32 with no kbd_clear -> kbd_data=0xC1 and one overrun pulse.
REQ-038 With KBD_FIFO_EN: 5 keys with no kbd_clear -> no overrun; a 6th key -> overrun pulse; after 5 kbd_clear strobes the keys are read in order.

Source files
------------

// File: rtl/kbd_ps2_pia_pkg.sv
// mango_kbd_pkg: shared PS/2 frame states, scancodes and ASCII codes for the keyboard PIA.
package mango_kbd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;
  typedef struct packed {
    logic       valid;
    logic [6:0] ascii;
  } key_t;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [6:0] ASC_CR     = 7'h0D;
  localparam logic [6:0] ASC_RUBOUT = 7'h5F;
  localparam logic [6:0] ASC_SPACE  = 7'h20;
  localparam logic [6:0] ASC_ESC    = 7'h1B;
  function automatic logic is_shift(input logic [7:0] sc);
    return sc == SC_LSHIFT || sc == SC_RSHIFT;
  endfunction
endpackage

// File: rtl/kbd_ps2_pia_if.sv
// kbd_ps2_pia_if: CPU-side key register bus of the PS/2 keyboard PIA.
interface kbd_ps2_pia_if;
  logic [7:0] kbd_data;
  logic       kbd_clear;
  logic       frame_err;
  logic       overrun;
  modport master (input kbd_data, frame_err, overrun, output kbd_clear);
  modport slave (output kbd_data, frame_err, overrun, input kbd_clear);
endinterface

// File: rtl/kbd_ps2_pia_ps2_rx.sv
// ps2_rx: synchronises and glitch-filters the PS/2 lines and deframes 11-bit keyboard frames.
module ps2_rx import mango_kbd_pkg::*; #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, fall, sclk, sdat;
  logic [CW-1:0] flt_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q, byte_q;
  logic          par_q, valid_q, err_q;
  rx_state_e     state_q;
  assign sclk = clk_sync_q[1];
  assign sdat = dat_sync_q[1];
  // Falls on the cycle the filtered level is about to drop, so the FSM samples in step with it.
  assign fall = filt_q && !sclk && flt_cnt_q == CW'(FILTER_LEN - 1);
  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign err_o        = err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      if (sclk == filt_q) flt_cnt_q <= '0;
      else if (flt_cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q    <= sclk;
        flt_cnt_q <= '0;
      end else flt_cnt_q <= flt_cnt_q + 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= ST_IDLE;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= (fall || state_q == ST_IDLE) ? '0 : to_cnt_q + 1'b1;
      if (fall)
        case (state_q)
          ST_IDLE: if (!sdat) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
          ST_DATA: begin
            shift_q   <= {sdat, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= sdat;
            state_q <= ST_STOP;
          end
          default: begin
            state_q <= ST_IDLE;
            if (sdat && ^{shift_q, par_q}) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else err_q <= 1'b1;
          end
        endcase
      else if (state_q != ST_IDLE && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b1;
      end
    end
endmodule

// File: rtl/kbd_ps2_pia.sv
// kbd_ps2_pia: PS/2 set-2 keyboard to 7-bit ASCII key register with key-available flag.
// Define KBD_FIFO_EN to add a 4-entry type-ahead FIFO ahead of the key latch.
module kbd_ps2_pia import mango_kbd_pkg::*; #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  kbd_ps2_pia_if.slave  bus
);
  logic [7:0] rx_byte, kbd_q, kbd_d;
  logic       rx_valid, rx_err, brk_q, ext_q, shift_q, char_v_q, ovr_q, ovr_d, ready, load;
  logic [6:0] char_q, load_char;
  key_t       key;
  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_o(rx_byte), .byte_valid_o(rx_valid), .err_o(rx_err)
  );
  function automatic key_t sc2key(input logic [7:0] sc, input logic sh);
    logic [6:0] a;
    case (sc)
      8'h1C: a = 7'h41; 8'h32: a = 7'h42; 8'h21: a = 7'h43; 8'h23: a = 7'h44;
      8'h24: a = 7'h45; 8'h2B: a = 7'h46; 8'h34: a = 7'h47; 8'h33: a = 7'h48;
      8'h43: a = 7'h49; 8'h3B: a = 7'h4A; 8'h42: a = 7'h4B; 8'h4B: a = 7'h4C;
      8'h3A: a = 7'h4D; 8'h31: a = 7'h4E; 8'h44: a = 7'h4F; 8'h4D: a = 7'h50;
      8'h15: a = 7'h51; 8'h2D: a = 7'h52; 8'h1B: a = 7'h53; 8'h2C: a = 7'h54;
      8'h3C: a = 7'h55; 8'h2A: a = 7'h56; 8'h1D: a = 7'h57; 8'h22: a = 7'h58;
      8'h35: a = 7'h59; 8'h1A: a = 7'h5A;
      8'h16: a = sh ? 7'h21 : 7'h31; 8'h1E: a = sh ? 7'h40 : 7'h32;
      8'h26: a = sh ? 7'h23 : 7'h33; 8'h25: a = sh ? 7'h24 : 7'h34;
      8'h2E: a = sh ? 7'h25 : 7'h35; 8'h36: a = sh ? 7'h5E : 7'h36;
      8'h3D: a = sh ? 7'h26 : 7'h37; 8'h3E: a = sh ? 7'h2A : 7'h38;
      8'h46: a = sh ? 7'h28 : 7'h39; 8'h45: a = sh ? 7'h29 : 7'h30;
      8'h0E: a = sh ? 7'h7E : 7'h60; 8'h4E: a = sh ? 7'h5F : 7'h2D;
      8'h55: a = sh ? 7'h2B : 7'h3D; 8'h54: a = sh ? 7'h7B : 7'h5B;
      8'h5B: a = sh ? 7'h7D : 7'h5D; 8'h5D: a = sh ? 7'h7C : 7'h5C;
      8'h4C: a = sh ? 7'h3A : 7'h3B; 8'h52: a = sh ? 7'h22 : 7'h27;
      8'h41: a = sh ? 7'h3C : 7'h2C; 8'h49: a = sh ? 7'h3E : 7'h2E;
      8'h4A: a = sh ? 7'h3F : 7'h2F;
      SC_ENTER: a = ASC_CR;
      SC_BKSP:  a = ASC_RUBOUT;
      SC_SPACE: a = ASC_SPACE;
      SC_ESC:   a = ASC_ESC;
      default:  a = 7'h00;
    endcase
    return {a != 7'h00, a};
  endfunction
  assign key = sc2key(rx_byte, shift_q);
  // Prefix flags persist until the next ordinary byte, which consumes and clears both.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      shift_q  <= 1'b0;
      char_v_q <= 1'b0;
      char_q   <= '0;
    end else begin
      char_v_q <= 1'b0;
      if (rx_valid) begin
        if (rx_byte == SC_BREAK) brk_q <= 1'b1;
        else if (rx_byte == SC_EXT) ext_q <= 1'b1;
        else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (!ext_q && is_shift(rx_byte)) shift_q <= !brk_q;
          else if (!ext_q && !brk_q && key.valid) begin
            char_v_q <= 1'b1;
            char_q   <= key.ascii;
          end
        end
      end
    end
  assign ready = !kbd_q[7] || bus.kbd_clear;
`ifdef KBD_FIFO_EN
  logic [6:0] mem_q [4];
  logic [1:0] rd_q, wr_q;
  logic [2:0] cnt_q;
  logic       pop, push;
  // A new key bypasses the FIFO only when it is empty and the latch can take it now.
  assign pop       = ready && cnt_q != 3'd0;
  assign ovr_d     = char_v_q && !ready && cnt_q == 3'd4;
  assign push      = char_v_q && !(ready && cnt_q == 3'd0) && !ovr_d;
  assign load      = pop || (ready && char_v_q);
  assign load_char = pop ? mem_q[rd_q] : char_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= char_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 2'd1;
      if (pop) rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
    end
`else
  assign load      = ready && char_v_q;
  assign load_char = char_q;
  assign ovr_d     = char_v_q && !ready;
`endif
  assign kbd_d = load ? {1'b1, load_char} : {kbd_q[7] && !bus.kbd_clear, kbd_q[6:0]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      kbd_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      kbd_q <= kbd_d;
      ovr_q <= ovr_d;
    end
  assign bus.kbd_data  = kbd_q;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = rx_err;
endmodule

// File: tb/tb_kbd_ps2_pia.sv
// tb_kbd_ps2_pia: directed bench for the PS/2 keyboard PIA, default parameters.
module tb_kbd_ps2_pia;
  logic clk = 1'b0, reset = 1'b1, ps2c = 1'b1, ps2d = 1'b1;
  int vec = 0, miss = 0, err_cnt = 0, ovr_cnt = 0;
  kbd_ps2_pia_if bus ();
  kbd_ps2_pia dut (.clk(clk), .reset(reset), .ps2_clk(ps2c), .ps2_data(ps2d), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.overrun === 1'b1) ovr_cnt++;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    ps2d = b; cyc(12); ps2c = 1'b0; cyc(20); ps2c = 1'b1; cyc(20);
  endtask
  task automatic send_raw(input logic [7:0] b, input logic pbad, input logic sbad);
    logic [10:0] f;
    f = {~sbad, ~(^b) ^ pbad, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2d = 1'b1; cyc(4);
  endtask
  task automatic send_frame(input logic [7:0] b);
    send_raw(b, 1'b0, 1'b0);
  endtask
  task automatic strobe_clear();
    bus.kbd_clear = 1'b1; cyc(1); bus.kbd_clear = 1'b0; cyc(1);
  endtask
  task automatic do_reset();
    reset = 1'b1; cyc(3); reset = 1'b0; cyc(3);
  endtask
  task automatic test_reset();
    bus.kbd_clear = 1'b0; reset = 1'b1; cyc(3);
    vec++; if (bus.kbd_data !== 8'h00) begin miss++; $display("FAIL reset_kbd_data got %h exp 00", bus.kbd_data); end
    vec++; if (bus.frame_err !== 1'b0) begin miss++; $display("FAIL reset_frame_err got %b exp 0", bus.frame_err); end
    vec++; if (bus.overrun !== 1'b0) begin miss++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
    reset = 1'b0; cyc(5);
  endtask
  task automatic test_latency();
    logic [10:0] f;
    f = {1'b1, ~(^8'h1C), 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    ps2d = 1'b1; cyc(12); ps2c = 1'b0; cyc(11);
    vec++; if (bus.kbd_data !== 8'h00) begin miss++; $display("FAIL latency_early got %h exp 00", bus.kbd_data); end
    cyc(1);
    vec++; if (bus.kbd_data !== 8'hC1) begin miss++; $display("FAIL latency_load got %h exp c1", bus.kbd_data); end
    cyc(8); ps2c = 1'b1; cyc(20);
  endtask
  task automatic test_clear();
    strobe_clear();
    vec++; if (bus.kbd_data !== 8'h41) begin miss++; $display("FAIL clear_keeps_ascii got %h exp 41", bus.kbd_data); end
  endtask
  task automatic test_shift();
    int e0, o0;
    e0 = err_cnt; o0 = ovr_cnt;
    send_frame(8'h12); send_frame(8'h16);
    vec++; if (bus.kbd_data !== 8'hA1) begin miss++; $display("FAIL shift_bang got %h exp a1", bus.kbd_data); end
    send_frame(8'hF0); send_frame(8'h16); send_frame(8'hF0); send_frame(8'h12);
    vec++; if (bus.kbd_data !== 8'hA1) begin miss++; $display("FAIL shift_breaks_silent got %h exp a1", bus.kbd_data); end
    vec++; if (ovr_cnt - o0 !== 0) begin miss++; $display("FAIL shift_no_overrun got %0d exp 0", ovr_cnt - o0); end
    strobe_clear();
    vec++; if (bus.kbd_data !== 8'h21) begin miss++; $display("FAIL shift_clear got %h exp 21", bus.kbd_data); end
    send_frame(8'h16);
    vec++; if (bus.kbd_data !== 8'hB1) begin miss++; $display("FAIL shift_released got %h exp b1", bus.kbd_data); end
    vec++; if (err_cnt - e0 !== 0) begin miss++; $display("FAIL shift_no_err got %0d exp 0", err_cnt - e0); end
  endtask
  task automatic test_reset_midframe();
    int e0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1; #2;
    vec++; if (bus.kbd_data !== 8'h00) begin miss++; $display("FAIL async_reset got %h exp 00", bus.kbd_data); end
    cyc(3); reset = 1'b0; cyc(3);
    e0 = err_cnt;
    send_frame(8'h1C);
    vec++; if (bus.kbd_data !== 8'hC1) begin miss++; $display("FAIL fresh_frame got %h exp c1", bus.kbd_data); end
    vec++; if (err_cnt - e0 !== 0) begin miss++; $display("FAIL fresh_frame_err got %0d exp 0", err_cnt - e0); end
  endtask
  task automatic test_parity();
    int e0;
    do_reset(); e0 = err_cnt;
    send_raw(8'h1C, 1'b1, 1'b0);
    vec++; if (err_cnt - e0 !== 1) begin miss++; $display("FAIL parity_err got %0d exp 1", err_cnt - e0); end
    vec++; if (bus.kbd_data !== 8'h00) begin miss++; $display("FAIL parity_discard got %h exp 00", bus.kbd_data); end
    send_raw(8'h1C, 1'b0, 1'b1);
    vec++; if (err_cnt - e0 !== 2) begin miss++; $display("FAIL stop_err got %0d exp 2", err_cnt - e0); end
    vec++; if (bus.kbd_data !== 8'h00) begin miss++; $display("FAIL stop_discard got %h exp 00", bus.kbd_data); end
    send_bit(1'b1); cyc(5);
    vec++; if (err_cnt - e0 !== 2) begin miss++; $display("FAIL start1_no_err got %0d exp 2", err_cnt - e0); end
    send_frame(8'h1C);
    vec++; if (bus.kbd_data !== 8'hC1) begin miss++; $display("FAIL start1_idle got %h exp c1", bus.kbd_data); end
  endtask
  task automatic test_timeout();
    int e0;
    do_reset(); e0 = err_cnt;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    cyc(20100);
    vec++; if (err_cnt - e0 !== 1) begin miss++; $display("FAIL timeout_err got %0d exp 1", err_cnt - e0); end
    vec++; if (bus.kbd_data !== 8'h00) begin miss++; $display("FAIL timeout_no_key got %h exp 00", bus.kbd_data); end
    send_frame(8'h5A);
    vec++; if (bus.kbd_data !== 8'h8D) begin miss++; $display("FAIL timeout_recover got %h exp 8d", bus.kbd_data); end
  endtask
  task automatic test_extended();
    strobe_clear();
    send_frame(8'hE0); send_frame(8'h1C);
    vec++; if (bus.kbd_data !== 8'h0D) begin miss++; $display("FAIL ext_ignored got %h exp 0d", bus.kbd_data); end
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h1C);
    vec++; if (bus.kbd_data !== 8'h0D) begin miss++; $display("FAIL ext_break_ignored got %h exp 0d", bus.kbd_data); end
    send_frame(8'h1C);
    vec++; if (bus.kbd_data !== 8'hC1) begin miss++; $display("FAIL ext_cleared got %h exp c1", bus.kbd_data); end
    strobe_clear();
    send_frame(8'hE0); send_frame(8'h12); send_frame(8'h16);
    vec++; if (bus.kbd_data !== 8'hB1) begin miss++; $display("FAIL ext_shift_ignored got %h exp b1", bus.kbd_data); end
    strobe_clear();
  endtask
  task automatic test_specials();
    send_frame(8'h29);
    vec++; if (bus.kbd_data !== 8'hA0) begin miss++; $display("FAIL space got %h exp a0", bus.kbd_data); end
    strobe_clear(); send_frame(8'h76);
    vec++; if (bus.kbd_data !== 8'h9B) begin miss++; $display("FAIL escape got %h exp 9b", bus.kbd_data); end
    strobe_clear(); send_frame(8'h66);
    vec++; if (bus.kbd_data !== 8'hDF) begin miss++; $display("FAIL backspace got %h exp df", bus.kbd_data); end
    strobe_clear(); send_frame(8'h59); send_frame(8'h4E);
    vec++; if (bus.kbd_data !== 8'hDF) begin miss++; $display("FAIL shift_minus got %h exp df", bus.kbd_data); end
    send_frame(8'hF0); send_frame(8'h59); strobe_clear();
    vec++; if (bus.kbd_data !== 8'h5F) begin miss++; $display("FAIL cleared_underscore got %h exp 5f", bus.kbd_data); end
    send_frame(8'h05);
    vec++; if (bus.kbd_data !== 8'h5F) begin miss++; $display("FAIL unmapped got %h exp 5f", bus.kbd_data); end
    send_frame(8'h4E);
    vec++; if (bus.kbd_data !== 8'hAD) begin miss++; $display("FAIL minus got %h exp ad", bus.kbd_data); end
  endtask
`ifdef KBD_FIFO_EN
  task automatic test_overrun();
    logic [7:0] sc [6];
    logic [7:0] ex [5];
    int o0;
    sc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    ex = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    do_reset(); o0 = ovr_cnt;
    for (int i = 0; i < 5; i++) send_frame(sc[i]);
    vec++; if (ovr_cnt - o0 !== 0) begin miss++; $display("FAIL fifo_no_overrun got %0d exp 0", ovr_cnt - o0); end
    send_frame(sc[5]);
    vec++; if (ovr_cnt - o0 !== 1) begin miss++; $display("FAIL fifo_overrun got %0d exp 1", ovr_cnt - o0); end
    for (int i = 0; i < 5; i++) begin
      vec++; if (bus.kbd_data !== ex[i]) begin miss++; $display("FAIL fifo_order_%0d got %h exp %h", i, bus.kbd_data, ex[i]); end
      strobe_clear();
    end
    vec++; if (bus.kbd_data !== 8'h45) begin miss++; $display("FAIL fifo_drained got %h exp 45", bus.kbd_data); end
  endtask
`else
  task automatic test_overrun();
    int o0;
    do_reset(); o0 = ovr_cnt;
    send_frame(8'h1C); send_frame(8'h32);
    vec++; if (bus.kbd_data !== 8'hC1) begin miss++; $display("FAIL overrun_keep got %h exp c1", bus.kbd_data); end
    vec++; if (ovr_cnt - o0 !== 1) begin miss++; $display("FAIL overrun_pulse got %0d exp 1", ovr_cnt - o0); end
    strobe_clear();
    vec++; if (bus.kbd_data !== 8'h41) begin miss++; $display("FAIL overrun_clear got %h exp 41", bus.kbd_data); end
  endtask
`endif
  initial begin
    test_reset();
    test_latency();
    test_clear();
    test_shift();
    test_reset_midframe();
    test_parity();
    test_timeout();
    test_extended();
    test_specials();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
